// File: rtl/mx_blk_align_pkg.sv
// Shared types and constants for the MX block aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mx_align_pkg;

    // Block controller phases: collect a block, then drain it.
    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int INT_W_DEF = 24;
    localparam int OUT_W_DEF = 8;

    // Shift amounts run 0..int_w inclusive, hence the +1.
    localparam int shift_w = $clog2(INT_W_DEF + 1);

    // Signed saturation bounds of an out_w-bit element.
    function automatic int sat_max(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    function automatic int sat_min(input int ow);
        return -(1 << (ow - 1));
    endfunction

endpackage

// File: rtl/mx_blk_align_elem_rnd.sv
// Element aligner: arithmetic right shift, optional RNE rounding, saturation.
// Latency: purely combinational.
// Backpressure: none (no state). Rounding enabled by macro MX_ALIGN_RNE_EN.
//
// Ports: i_op  signed element, i_sh  right-shift amount 0..int_w,
//        o_elem  saturated signed out_w-bit result.
module mx_elem_rnd
    import mx_align_pkg::*;
#(
    parameter int int_w = 24,
    parameter int out_w = 8
) (
    input  logic [int_w-1:0]             i_op,
    input  logic [$clog2(int_w+1)-1:0]   i_sh,
    output logic [out_w-1:0]             o_elem
);

    // Two guard bits of headroom: one for the sh==int_w case, one for the
    // rounding increment.
    localparam int EW = int_w + 2;
    localparam logic signed [EW-1:0] MAXV = EW'(sat_max(out_w));
    localparam logic signed [EW-1:0] MINV = EW'(sat_min(out_w));

    logic signed [EW-1:0] w_op_ext;
    logic signed [EW-1:0] w_shr;
    logic signed [EW-1:0] w_sum;

    assign w_op_ext = $signed({{2{i_op[int_w-1]}}, i_op});
    assign w_shr    = w_op_ext >>> i_sh;

`ifdef MX_ALIGN_RNE_EN
    logic [EW-1:0] w_low;      // ones on every bit shifted out
    logic [EW-1:0] w_guard_m;  // just bit sh-1
    logic          w_guard;
    logic          w_sticky;
    logic          w_rnd;

    assign w_low     = (EW'(1) << i_sh) - EW'(1);
    assign w_guard_m = w_low ^ (w_low >> 1);
    assign w_guard   = |(w_op_ext & w_guard_m);
    assign w_sticky  = |(w_op_ext & (w_low >> 1));
    assign w_rnd     = w_guard & (w_sticky | w_shr[0]);
    assign w_sum     = w_shr + $signed({{(EW-1){1'b0}}, w_rnd});
`else
    assign w_sum     = w_shr;
`endif

    always_comb begin
        o_elem = w_sum[out_w-1:0];
        if (w_sum > MAXV) begin
            o_elem = MAXV[out_w-1:0];
        end else if (w_sum < MINV) begin
            o_elem = MINV[out_w-1:0];
        end
    end

endmodule

// File: rtl/mx_blk_align.sv
// Packs blk_sz normalised (op, scale) elements into one MX block: shared scale + narrow elements.
// Latency: first output 1 cycle after the last input accept; FILL and EMIT never overlap.
// Backpressure: o_ready only in FILL; in EMIT outputs hold while i_ready is low.
//
// Ports: i_clk/i_rst (sync, active-high); input stream i_valid/o_ready/i_op/i_scale;
//        output stream o_valid/i_ready/o_elem/o_scale/o_last.
// Optional macro MX_ALIGN_RNE_EN selects round-to-nearest-even instead of truncation.
module mx_blk_align
    import mx_align_pkg::*;
#(
    parameter int int_w   = 24,
    parameter int scale_w = 8,
    parameter int out_w   = 8,
    parameter int blk_sz  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [int_w-1:0]   i_op,
    input  logic [scale_w-1:0] i_scale,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [out_w-1:0]   o_elem,
    output logic [scale_w-1:0] o_scale,
    output logic               o_last
);

    localparam int SH_W  = $clog2(int_w + 1);
    localparam int IDX_W = $clog2(blk_sz);
    localparam int OFS   = int_w - out_w;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [scale_w-1:0] r_max;
    logic               r_nz;
    logic [scale_w-1:0] r_scale;
    logic [int_w-1:0]   r_op_buf [blk_sz];
    logic [scale_w-1:0] r_sc_buf [blk_sz];

    logic               w_last;
    logic               w_op_nz;
    logic [scale_w-1:0] w_max_nxt;
    logic               w_nz_nxt;
    logic [scale_w:0]   w_scale_sum;
    logic [scale_w-1:0] w_scale_blk;
    logic [int_w-1:0]   w_rd_op;
    logic [scale_w-1:0] w_rd_sc;
    logic [scale_w+1:0] w_sh_full;
    logic [SH_W-1:0]    w_sh;
    logic [out_w-1:0]   w_elem;

    assign w_last  = (r_idx == IDX_W'(blk_sz - 1));
    assign w_op_nz = |i_op;

    // Zero elements carry arbitrary scales and must not pull the block scale up.
    assign w_max_nxt = (w_op_nz && (i_scale > r_max)) ? i_scale : r_max;
    assign w_nz_nxt  = r_nz | w_op_nz;

    // Shared scale is computed from the next-state max so the final accepted
    // element is included when the block closes.
    assign w_scale_sum = {1'b0, w_max_nxt} + (scale_w + 1)'(OFS);
    always_comb begin
        w_scale_blk = '0;
        if (w_nz_nxt) begin
            w_scale_blk = w_scale_sum[scale_w] ? '1 : w_scale_sum[scale_w-1:0];
        end
    end

    assign w_rd_op = r_op_buf[r_idx];
    assign w_rd_sc = r_sc_buf[r_idx];

    // Shift uses the unsaturated scale. A scale above the max can only belong
    // to a zero element, so clamping to full shift-out is harmless there.
    assign w_sh_full = {1'b0, {1'b0, r_max} - {1'b0, w_rd_sc}} + (scale_w + 2)'(OFS);
    always_comb begin
        w_sh = w_sh_full[SH_W-1:0];
        if ((w_rd_sc > r_max) || (w_sh_full > (scale_w + 2)'(int_w))) begin
            w_sh = SH_W'(int_w);
        end
    end

    mx_elem_rnd #(
        .int_w (int_w),
        .out_w (out_w)
    ) u_rnd (
        .i_op   (w_rd_op),
        .i_sh   (w_sh),
        .o_elem (w_elem)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_max   <= '0;
            r_nz    <= 1'b0;
            r_scale <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (i_valid) begin
                        r_max <= w_max_nxt;
                        r_nz  <= w_nz_nxt;
                        if (w_last) begin
                            r_state <= EMIT;
                            r_idx   <= '0;
                            r_scale <= w_scale_blk;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        if (w_last) begin
                            r_state <= FILL;
                            r_idx   <= '0;
                            r_max   <= '0;
                            r_nz    <= 1'b0;
                            r_scale <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Element storage needs no reset: every slot is rewritten before it is read.
    always_ff @(posedge i_clk) begin
        if (!i_rst && (r_state == FILL) && i_valid) begin
            r_op_buf[r_idx] <= i_op;
            r_sc_buf[r_idx] <= i_scale;
        end
    end

    assign o_ready = (r_state == FILL);
    assign o_valid = (r_state == EMIT);
    assign o_last  = o_valid & w_last;
    assign o_elem  = o_valid ? w_elem : '0;
    assign o_scale = r_scale;

endmodule

// File: doc/mx_blk_align.md
Name: mx_blk_align

Overview:
- Inverse of the normalising adder path: converts a stream of normalised (signed int, per-element scale) values back into an MX block with one shared scale and narrow signed elements.
- Collects `blk_sz` elements and tracks the maximum scale among non-zero elements.
- Then emits each element right-shifted to the shared scale, rounded, and saturated to `out_w` bits.
- Sits after the accumulate/normalise datapath, feeding MX block storage/output.

Parameters:
- `int_w`, 24, width of signed normalised input element
- `scale_w`, 8, width of unsigned scale (input and output)
- `out_w`, 8, width of signed output element (`out_w` < `int_w`)
- `blk_sz`, 32, elements per MX block (≥2)

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_valid`  in  1  input element valid
- `o_ready`  out  1  block can accept input
- `i_op`  in  `int_w`  signed normalised element
- `i_scale`  in  `scale_w`  element scale; value = `i_op`·2^`i_scale`
- `o_valid`  out  1  output element valid
- `i_ready`  in  1  downstream accepts output
- `o_elem`  out  `out_w`  signed aligned element; value = `o_elem`·2^`o_scale`
- `o_scale`  out  `scale_w`  shared block scale, stable for the whole emit phase
- `o_last`  out  1  high with final element of block

Behaviour:
- **Reset:** state FILL, index 0, max-scale cleared, any-nonzero flag cleared. Outputs: `o_ready`=1, `o_valid`=0, `o_elem`=0, `o_scale`=0, `o_last`=0. A reset in any state aborts the block; partial data is discarded.
- **FILL:**
  - `o_ready`=1. An accept happens when `i_valid`&`o_ready`; store `i_op`/`i_scale` in `buf[idx]`, idx++.
  - If `i_op`≠0: update max-scale (`max(cur, i_scale)`) and set the nonzero flag. Zero elements never affect the max.
  - On the accept with idx=`blk_sz`-1: next cycle enter EMIT with idx=0 and `o_scale` registered.
- **EMIT:**
  - `o_ready`=0, `o_valid`=1. `o_elem`=align(`buf[idx]`) is combinational from registers; `o_last`=(idx==`blk_sz`-1).
  - On `i_ready`: idx++. On `i_ready` with `o_last`: next cycle FILL, `o_ready`=1.
  - With `i_ready` low, all outputs hold stable.
- **Timing:** first output valid 1 cycle after the last input accept. Block throughput is 2·`blk_sz` cycles; FILL and EMIT never overlap.
- **Shared scale:**
  - `o_scale` = max_scale + (`int_w`−`out_w`), saturating at 2^`scale_w`−1.
  - All-zero block: `o_scale`=0 and every `o_elem`=0.
- **Align:**
  - sh = (max_scale − scale) + (`int_w`−`out_w`). sh is clamped to `int_w` (everything shifts out). Arithmetic right shift of `i_op` by sh.
  - Rounding per Optional Feature.
  - Saturate to [−2^(`out_w`−1), 2^(`out_w`−1)−1]; rounding overflow (e.g. 127.99→128) yields 127.
  - When scale saturated, sh is computed from the unsaturated value.
- **Simultaneous events:** `i_valid` during EMIT is ignored (not accepted). `i_ready` during FILL has no effect.

Optional Feature:
- Macro `MX_ALIGN_RNE_EN`.
- **Defined:** round-to-nearest-even using guard bit (bit sh−1), sticky (OR of bits below) and LSB. Round up iff guard & (sticky | LSB); then saturate.
- **Undefined:** pure arithmetic right shift (truncation toward −∞), no rounding logic, saturation still applied.

Decomposition:
- Package `mx_align_pkg`:
  - state enum {FILL, EMIT}
  - localparam `shift_w` = $clog2(`int_w`+1)
  - saturation constants derived from `out_w`
- Sub-module `mx_elem_rnd`: combinational shift/round/saturate. Inputs are op, sh, and params `int_w`/`out_w`; output is elem. Instantiated once on the buffer read path.

Test Plan (bench params `int_w`=24, `out_w`=8, `blk_sz`=4, `scale_w`=8):
- **Basic alignment:** ops {0x400000,0x400000,0x400000,0x400000}, scales {10,10,9,2} → `o_scale`=26, `o_elem` {64,64,32,0}. `o_last` on 4th; first `o_valid` 1 cycle after 4th accept.
- **Sign/zero handling:**
  - ops {0xC00000,0,0,0}, scales {5,200,200,200} → `o_scale`=21, elems {−64,0,0,0}; zeros do not raise max.
  - All-zero block → `o_scale`=0, elems all 0.
- **Rounding/saturation, `MX_ALIGN_RNE_EN` defined:** block of scale 5, ops {0x418000,0x408000,0x7FFFFF,0x800000} → {66,64,127,−128}. Macro undefined → {65,64,127,−128}.
- **Backpressure:** hold `i_ready` low 3 cycles mid-EMIT → `o_elem`/`o_scale`/`o_last` stable, `o_ready`=0. Drive `i_valid`=1 in EMIT → no element consumed. Next block accepted only after final handshake.
- **Reset:** assert `i_rst` for 1 cycle after 2 outputs emitted → next cycle FILL, `o_valid`=0, `o_ready`=1, `o_scale`=0. A fresh 4-element block then aligns correctly, uncontaminated by the prior max.
